// File: rtl/ev21g1_prefetch_if.sv
`default_nettype none
// ============================================================================
// Interface : ev21g1_prefetch_if
// Brief     : Bundles the instruction-memory port, the redirect request and
//             the decode-side valid/ready handshake of the prefetch unit.
// Revision  : 1.0 - initial release
// ============================================================================
interface ev21g1_prefetch_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  // Instruction memory side
  logic                   imem_en;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;

  // Branch redirect
  logic                   redirect_en;
  logic [ADDR_WIDTH-1:0]  redirect_pc;

  // Decode side
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic [c_cnt_w-1:0]     queue_count;

  // The prefetch unit
  modport master (
    output imem_en, imem_addr,
    input  imem_data,
    input  redirect_en, redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr_data, instr_pc, queue_count
  );

  // The environment: memory, branch unit and decode
  modport slave (
    input  imem_en, imem_addr,
    output imem_data,
    output redirect_en, redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr_data, instr_pc, queue_count
  );
endinterface
`default_nettype wire

// File: rtl/ev21g1_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ev21g1_prefetch
// Brief    : Sequential instruction prefetcher. Issues reads to a 1-cycle
//            synchronous instruction memory, queues returned words with their
//            PCs in a DEPTH-entry circular FIFO and hands them to decode.
//            A redirect flushes the queue and kills any in-flight read.
// Revision : 1.0 - initial release
// ============================================================================
module ev21g1_prefetch #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          INSTR_WIDTH = 32,
  parameter int          DEPTH       = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input wire                clk,
  input wire                reset,
  ev21g1_prefetch_if.master bus
);

  localparam int c_ptr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w  = $clog2(DEPTH + 1);
  localparam int c_occ_w  = c_cnt_w + 1;

  localparam logic [ADDR_WIDTH-1:0] c_reset_pc  = ADDR_WIDTH'(RESET_PC);
  localparam logic [c_ptr_w-1:0]    c_last_slot = c_ptr_w'(DEPTH - 1);
  localparam logic [c_occ_w-1:0]    c_depth     = c_occ_w'(DEPTH);

  // Architectural state
  logic [ADDR_WIDTH-1:0]  fetch_pc_q,  fetch_pc_d;
  logic [ADDR_WIDTH-1:0]  issued_pc_q, issued_pc_d;   // address of the read in flight
  logic                   inflight_q,  inflight_d;
  logic                   kill_q,      kill_d;
  logic [c_ptr_w-1:0]     rd_ptr_q,    rd_ptr_d;
  logic [c_ptr_w-1:0]     wr_ptr_q,    wr_ptr_d;
  logic [c_cnt_w-1:0]     count_q,     count_d;

  // Queue storage
  logic [INSTR_WIDTH-1:0] data_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem_q   [DEPTH];

  // Per-cycle decisions
  logic                   w_issue;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_valid;
  logic [c_occ_w-1:0]     w_occupancy;

  // Circular pointer advance; DEPTH need not be a power of two
  function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
    return (p == c_last_slot) ? '0 : p + c_ptr_w'(1);
  endfunction

  // Credit-based issue and handshake decode. Counting the in-flight read
  // against the queue capacity means a returning word always has a slot.
  always_comb begin
    w_occupancy = {1'b0, count_q} + {{c_cnt_w{1'b0}}, inflight_q};
    w_issue     = reset && !bus.redirect_en && (w_occupancy < c_depth);
    w_valid     = reset && !bus.redirect_en && (count_q != '0);
    w_push      = inflight_q && !kill_q && !bus.redirect_en;
    w_pop       = w_valid && bus.instr_ready;
  end

  // Next-state for fetch PC, in-flight tracking and queue bookkeeping;
  // a redirect overrides push and pop and restarts fetch at redirect_pc
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = w_issue;
    kill_d      = 1'b0;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    if (bus.redirect_en) begin
      fetch_pc_d = bus.redirect_pc;
      kill_d     = w_issue || inflight_q;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (w_issue) begin
        fetch_pc_d  = fetch_pc_q + ADDR_WIDTH'(1);
        issued_pc_d = fetch_pc_q;
      end
      if (w_push) begin
        wr_ptr_d = ptr_next(wr_ptr_q);
      end
      if (w_pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      if (w_push && !w_pop) begin
        count_d = count_q + c_cnt_w'(1);
      end else if (!w_push && w_pop) begin
        count_d = count_q - c_cnt_w'(1);
      end
    end
  end

  // Control state register; reset wins over a concurrent redirect and clears
  // the in-flight flag so the response arriving next cycle is never pushed
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q  <= c_reset_pc;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
      kill_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
      kill_q      <= kill_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // Queue storage: written on push, cleared by reset so the head reads zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (w_push) begin
      data_mem_q[wr_ptr_q] <= bus.imem_data;
      pc_mem_q[wr_ptr_q]   <= issued_pc_q;
    end
  end

  // Outputs; decode-facing values read zero while reset is held
  assign bus.imem_en     = w_issue;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = w_valid;
  assign bus.instr_data  = reset ? data_mem_q[rd_ptr_q] : '0;
  assign bus.instr_pc    = reset ? pc_mem_q[rd_ptr_q]   : '0;
  assign bus.queue_count = reset ? count_q              : '0;

endmodule
`default_nettype wire
